// File: rtl/aux_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : aux_input_debouncer
// Description : Two-flop synchronizer and debouncer for the 16 slide switches
//               and the resume push-button. Presents a stable switch vector
//               with a change pulse, and a clean button level with press and
//               release pulses. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module aux_input_debouncer #(
  parameter int SwtBit    = 16,
  parameter int StableCnt = 1000000,
  parameter int CntBit    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_raw,
  input  logic [SwtBit-1:0] swt_raw,
  output logic [SwtBit-1:0] swt,
  output logic              swt_changed,
  output logic              btn_level,
  output logic              btn_press,
  output logic              btn_release
);

  // Terminal count: an input must be seen this many extra cycles to be accepted
  localparam logic [CntBit-1:0] CNT_LAST = CntBit'(StableCnt - 1);
  localparam logic [CntBit-1:0] CNT_ONE  = CntBit'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  logic              btn_s1;
  logic              btn_s2;
  logic [SwtBit-1:0] swt_s1;
  logic [SwtBit-1:0] swt_s2;

  btn_state_t        state;
  logic [CntBit-1:0] bcnt;

  logic [SwtBit-1:0] cand;
  logic [CntBit-1:0] scnt;

  // Two-stage synchronizer for every asynchronous input bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      swt_s1 <= '0;
      swt_s2 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      swt_s1 <= swt_raw;
      swt_s2 <= swt_s1;
    end
  end

  // Button debounce FSM; a bounce back to the old level returns to the
  // settled state without any pulse, so the count restarts on the next try
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE_LOW;
      bcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (btn_s2) begin
            state <= WAIT_HIGH;
            bcnt  <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!btn_s2) begin
            state <= IDLE_LOW;
          end else if (bcnt == CNT_LAST) begin
            state     <= HIGH;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            bcnt <= bcnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!btn_s2) begin
            state <= WAIT_LOW;
            bcnt  <= '0;
          end
        end
        WAIT_LOW: begin
          if (btn_s2) begin
            state <= HIGH;
          end else if (bcnt == CNT_LAST) begin
            state       <= IDLE_LOW;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            bcnt <= bcnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          bcnt  <= '0;
        end
      endcase
    end
  end

  // Switch debounce: any bit change restarts the whole vector; once the
  // candidate has been stable long enough it is published if it differs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand        <= '0;
      scnt        <= '0;
      swt         <= '0;
      swt_changed <= 1'b0;
    end else begin
      swt_changed <= 1'b0;
      if (swt_s2 != cand) begin
        cand <= swt_s2;
        scnt <= '0;
      end else if (scnt != CNT_LAST) begin
        scnt <= scnt + CNT_ONE;
      end else if (swt != cand) begin
        swt         <= cand;
        swt_changed <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
